// File: rtl/mem_pkg.sv
// Shared constants for the SRAM request path: return ids and the default burst length.
package mem_pkg;

    typedef logic [1:0] id_t;

    localparam id_t ID_NONE   = 2'd0;
    localparam id_t ID_IFETCH = 2'd1;
    localparam id_t ID_DATA   = 2'd2;

    localparam int BURST_DEFAULT = 4;

endpackage

// File: rtl/burst_tracker.sv
// Tracks one master's outstanding burst read: set on an accepted read, cleared by its last returned word.
module burst_tracker
    import mem_pkg::*;
#(
    parameter int BURST = BURST_DEFAULT
) (
    input  logic clock,
    input  logic rst,
    input  logic accept_read,
    input  logic ret,
    output logic pend
);

    localparam int            CW       = (BURST > 1) ? $clog2(BURST) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(BURST - 1);

    logic [CW-1:0] cnt;

    // A return with nothing pending leaves the counter alone, so it can never wrap.
    always_ff @(posedge clock) begin
        if (rst) begin
            pend <= 1'b0;
            cnt  <= '0;
        end else if (accept_read) begin
            pend <= 1'b1;
            cnt  <= CNT_LOAD;
        end else if (ret && pend) begin
            if (cnt == '0) begin
                pend <= 1'b0;
            end else begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_arbiter2.sv
// Round-robin merge of the instruction-fetch (m0) and data (m1) ports onto the SRAM controller,
// with per-master read ordering and id-steered return data.
module mem_arbiter2
    import mem_pkg::*;
#(
    parameter int  BURST = BURST_DEFAULT,
    parameter id_t ID0   = ID_IFETCH,
    parameter id_t ID1   = ID_DATA
) (
    input  logic        clock,
    input  logic        rst,

    input  logic [29:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_writedatamask,
    output logic        m0_waitrequest,
    output logic [31:0] m0_readdata,
    output logic        m0_readdatavalid,

    input  logic [29:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_writedatamask,
    output logic        m1_waitrequest,
    output logic [31:0] m1_readdata,
    output logic        m1_readdatavalid,

    output logic [29:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_writedatamask,
    output id_t         mem_id,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  id_t         mem_readdataid
);

    logic last;
    logic pend0, pend1;
    logic elig0, elig1;
    logic gnt_vld, gnt_idx;
    logic sel_read, sel_write;
    logic accept;
    logic ret0, ret1;

    // A master with a read in flight is held off entirely to keep its own ordering.
    always_comb begin
        elig0   = (m0_read | m0_write) & ~pend0;
        elig1   = (m1_read | m1_write) & ~pend1;
        gnt_vld = elig0 | elig1;
        gnt_idx = 1'b0;
        if (elig0 && elig1) begin
            gnt_idx = ~last;
        end else if (elig1) begin
            gnt_idx = 1'b1;
        end
    end

    always_comb begin
        mem_address       = m0_address;
        mem_writedata     = m0_writedata;
        mem_writedatamask = m0_writedatamask;
        sel_read          = m0_read;
        sel_write         = m0_write;
        if (gnt_idx) begin
            mem_address       = m1_address;
            mem_writedata     = m1_writedata;
            mem_writedatamask = m1_writedatamask;
            sel_read          = m1_read;
            sel_write         = m1_write;
        end
    end

    // Read takes priority if a master illegally raises both.
    assign mem_read  = gnt_vld & sel_read;
    assign mem_write = gnt_vld & sel_write & ~sel_read;
    assign mem_id    = !gnt_vld ? ID_NONE : (gnt_idx ? ID1 : ID0);

    assign accept         = gnt_vld & ~mem_waitrequest;
    assign m0_waitrequest = (gnt_vld && !gnt_idx) ? mem_waitrequest : 1'b1;
    assign m1_waitrequest = (gnt_vld &&  gnt_idx) ? mem_waitrequest : 1'b1;

    assign ret0 = (mem_readdataid != ID_NONE) && (mem_readdataid == ID0);
    assign ret1 = (mem_readdataid != ID_NONE) && (mem_readdataid == ID1);

    assign m0_readdatavalid = ret0;
    assign m1_readdatavalid = ret1;
    assign m0_readdata      = mem_readdata;
    assign m1_readdata      = mem_readdata;

    // Reset value 1 lets m0 win the first tie.
    always_ff @(posedge clock) begin
        if (rst) begin
            last <= 1'b1;
        end else if (accept) begin
            last <= gnt_idx;
        end
    end

    burst_tracker #(.BURST(BURST)) u_track0 (
        .clock       (clock),
        .rst         (rst),
        .accept_read (accept & ~gnt_idx & sel_read),
        .ret         (ret0),
        .pend        (pend0)
    );

    burst_tracker #(.BURST(BURST)) u_track1 (
        .clock       (clock),
        .rst         (rst),
        .accept_read (accept & gnt_idx & sel_read),
        .ret         (ret1),
        .pend        (pend1)
    );

endmodule

// File: tb/tb_mem_arbiter2.sv
// Randomized and directed bench for mem_arbiter2 against a words-remaining reference model.
module tb_mem_arbiter2;
    import mem_pkg::*;

    localparam int BURST = 4;

    logic        clock = 1'b0;
    logic        rst;
    logic        rd     [2];
    logic        wr     [2];
    logic [29:0] addr   [2];
    logic [31:0] wdata  [2];
    logic [3:0]  mask   [2];
    logic        waitreq[2];
    logic [31:0] rdata_o[2];
    logic        rvalid [2];

    logic [29:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_writedatamask;
    logic [1:0]  mem_id;
    logic        mem_waitrequest;
    logic [31:0] mem_readdata;
    logic [1:0]  mem_readdataid;

    int errors = 0;
    int checks = 0;
    int rem[2];
    int last_m;

    always #5 clock = ~clock;

    mem_arbiter2 #(.BURST(BURST), .ID0(2'd1), .ID1(2'd2)) dut (
        .clock             (clock),
        .rst               (rst),
        .m0_address        (addr[0]),
        .m0_read           (rd[0]),
        .m0_write          (wr[0]),
        .m0_writedata      (wdata[0]),
        .m0_writedatamask  (mask[0]),
        .m0_waitrequest    (waitreq[0]),
        .m0_readdata       (rdata_o[0]),
        .m0_readdatavalid  (rvalid[0]),
        .m1_address        (addr[1]),
        .m1_read           (rd[1]),
        .m1_write          (wr[1]),
        .m1_writedata      (wdata[1]),
        .m1_writedatamask  (mask[1]),
        .m1_waitrequest    (waitreq[1]),
        .m1_readdata       (rdata_o[1]),
        .m1_readdatavalid  (rvalid[1]),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_writedata     (mem_writedata),
        .mem_writedatamask (mem_writedatamask),
        .mem_id            (mem_id),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdataid    (mem_readdataid)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic req(input int m, input bit is_rd, input logic [29:0] a);
        rd[m]    = is_rd;
        wr[m]    = !is_rd;
        addr[m]  = a;
        wdata[m] = $urandom;
        mask[m]  = 4'($urandom);
    endtask

    // One clock: predict and check outputs mid-cycle, advance the model, then retire accepted requests.
    task automatic cycle();
        bit e[2];
        bit gv;
        bit acc;
        int g;
        @(negedge clock);
        for (int m = 0; m < 2; m++) e[m] = (rd[m] || wr[m]) && (rem[m] == 0);
        gv = e[0] || e[1];
        if (e[0] && e[1]) g = (last_m == 0) ? 1 : 0;
        else              g = e[1] ? 1 : 0;
        check_val("mem_read",  64'(mem_read),  64'(gv && rd[g]));
        check_val("mem_write", 64'(mem_write), 64'(gv && wr[g] && !rd[g]));
        if (gv) begin
            check_val("mem_id",      64'(mem_id),            64'(g + 1));
            check_val("mem_address", 64'(mem_address),       64'(addr[g]));
            check_val("mem_wdata",   64'(mem_writedata),     64'(wdata[g]));
            check_val("mem_mask",    64'(mem_writedatamask), 64'(mask[g]));
        end
        for (int m = 0; m < 2; m++) begin
            check_val($sformatf("m%0d_waitrequest", m), 64'(waitreq[m]),
                      64'((gv && g == m) ? mem_waitrequest : 1'b1));
            check_val($sformatf("m%0d_readdatavalid", m), 64'(rvalid[m]),
                      64'(int'(mem_readdataid) == m + 1));
            if (int'(mem_readdataid) == m + 1)
                check_val($sformatf("m%0d_readdata", m), 64'(rdata_o[m]), 64'(mem_readdata));
        end
        acc = gv && !mem_waitrequest;
        if (rst) begin
            last_m = 1;
            rem[0] = 0;
            rem[1] = 0;
        end else begin
            for (int m = 0; m < 2; m++)
                if (int'(mem_readdataid) == m + 1 && rem[m] > 0) rem[m]--;
            if (acc) begin
                last_m = g;
                if (rd[g]) rem[g] = BURST;
            end
        end
        @(posedge clock);
        #1;
        if (acc) begin
            rd[g] = 1'b0;
            wr[g] = 1'b0;
        end
        mem_readdataid = 2'd0;
        mem_readdata   = $urandom;
    endtask

    initial begin
        for (int m = 0; m < 2; m++) begin
            rd[m] = 0; wr[m] = 0; addr[m] = '0; wdata[m] = '0; mask[m] = '0; rem[m] = 0;
        end
        last_m          = 1;
        rst             = 1'b1;
        mem_waitrequest = 1'b0;
        mem_readdata    = '0;
        mem_readdataid  = 2'd0;
        @(posedge clock);
        #1;
        cycle();
        cycle();
        rst = 1'b0;

        // Contention: both masters write continuously; m0 takes the first tie.
        for (int i = 0; i < 6; i++) begin
            for (int m = 0; m < 2; m++) if (!wr[m]) req(m, 1'b0, 30'($urandom));
            cycle();
        end
        for (int m = 0; m < 2; m++) begin rd[m] = 0; wr[m] = 0; end

        // Reset, then a single m0 burst read and an immediate follow-up read.
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req(0, 1'b1, 30'h100);
        cycle();
        for (int i = 0; i < BURST; i++) begin mem_readdataid = 2'd1; cycle(); end
        req(0, 1'b1, 30'h140);
        cycle();
        for (int i = 0; i < BURST; i++) begin mem_readdataid = 2'd1; cycle(); end

        // Ordering: m1's write waits for its read burst while m0 writes flow.
        req(1, 1'b1, 30'h200);
        cycle();
        req(1, 1'b0, 30'h204);
        for (int i = 0; i < 9; i++) begin
            if (!wr[0]) req(0, 1'b0, 30'($urandom));
            if (i inside {1, 2, 4, 6}) mem_readdataid = 2'd2;
            cycle();
        end
        rd[0] = 0; wr[0] = 0;
        cycle();

        // Back-pressure: no accept and no pointer movement while the controller stalls.
        mem_waitrequest = 1'b1;
        req(0, 1'b0, 30'h3a0);
        for (int i = 0; i < 10; i++) begin
            if (i == 5) req(1, 1'b0, 30'h3b0);
            cycle();
        end
        mem_waitrequest = 1'b0;
        cycle();
        cycle();

        // Interleaved: m0 burst returns while m1 writes are accepted.
        req(0, 1'b1, 30'h300);
        cycle();
        for (int i = 0; i < BURST; i++) begin
            mem_readdataid = 2'd1;
            if (!wr[1]) req(1, 1'b0, 30'($urandom));
            cycle();
        end
        rd[1] = 0; wr[1] = 0;

        // Reset mid-burst: stale words still strobe, m0 may read again at once.
        req(0, 1'b1, 30'h400);
        cycle();
        for (int i = 0; i < 2; i++) begin mem_readdataid = 2'd1; cycle(); end
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        req(0, 1'b1, 30'h500);
        mem_readdataid = 2'd1;
        cycle();
        for (int i = 0; i < BURST + 1; i++) begin mem_readdataid = 2'd1; cycle(); end

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            int r;
            for (int m = 0; m < 2; m++)
                if (!rd[m] && !wr[m] && $urandom_range(0, 2) != 0)
                    req(m, $urandom_range(0, 2) == 0, 30'($urandom));
            mem_waitrequest = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 9);
            if (r < 4 && rem[0] > 0)      mem_readdataid = 2'd1;
            else if (r < 8 && rem[1] > 0) mem_readdataid = 2'd2;
            else if (r == 9)              mem_readdataid = 2'd3;
            rst = ($urandom_range(0, 199) == 0);
            cycle();
        end
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter2.md
# mem_arbiter2

Two-master request arbiter in front of the 16-bit SRAM controller. Merges an instruction-fetch port (m0) and a data port (m1) onto the controller's single word-addressed request port. Round-robin fairness, a unique return id per master, and tracking of each master's outstanding burst read. Returned read words are steered back to the owning master by id.

## Interface

Parameters:
- `BURST`, 4: words returned per read; must equal the controller's burst length.
- `ID0`, 2'd1: return id assigned to m0.
- `ID1`, 2'd2: return id assigned to m1. Id 0 is reserved for "no data".

Ports (`mN_*` exists for N = 0 and 1):
- `clock`  in  1  sole clock; everything on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `mN_address`  in  30  word address.
- `mN_read`  in  1  read request; held until accepted.
- `mN_write`  in  1  write request; held until accepted.
- `mN_writedata`  in  32  write data.
- `mN_writedatamask`  in  4  byte enables, active high.
- `mN_waitrequest`  out  1  high = request not accepted this cycle.
- `mN_readdata`  out  32  returned word.
- `mN_readdatavalid`  out  1  one-cycle strobe per returned word.
- `mem_address`  out  30  to controller.
- `mem_read`  out  1  to controller.
- `mem_write`  out  1  to controller.
- `mem_writedata`  out  32  to controller.
- `mem_writedatamask`  out  4  to controller.
- `mem_id`  out  2  to controller: ID0 or ID1.
- `mem_waitrequest`  in  1  from controller.
- `mem_readdata`  in  32  from controller.
- `mem_readdataid`  in  2  from controller; nonzero marks a valid word.

## Operation

- **Eligibility.** A master is eligible when its read or write is high, and it is not blocked by its own pending read. A master with a read pending (`pendN` = 1) is ineligible for both reads and writes until its last word returns. This guarantees per-master ordering.
- **Grant.** Combinational, computed from eligibility and the registered `last` pointer (0/1).
  - If both masters are eligible, grant the one that is not `last`.
  - If only one is eligible, grant it.
  - Otherwise there is no grant.
- **Drive.** The granted master's fields drive `mem_*`, and `mem_id` is set to that master's id. With no grant, `mem_read` and `mem_write` are 0 and the other `mem_*` outputs are don't-care.
- **Accept.** A request is accepted when it is granted and `mem_waitrequest` is 0.
  - The granted master sees `mN_waitrequest` equal to `mem_waitrequest`.
  - The non-granted master sees `mN_waitrequest` = 1.
- **On accept:**
  - `last` is set to the granted index.
  - For a read, `pendN` is set to 1 and `cntN` to BURST-1.
- **Return.**
  - When `mem_readdataid` == IDN, `mN_readdatavalid` = 1 and `mN_readdata` = `mem_readdata`. Both are combinational pass-through with 0 added latency.
  - Each returned word decrements `cntN`. If the word arrives while `cntN` == 0, `pendN` clears.
  - A returned id matching neither master is ignored.
- **Simultaneous events.** An accept and a return for the other master may occur in the same cycle; both take effect. The final word return and a new accept for the same master cannot coincide, because the master stays ineligible until the cycle after `pendN` clears.
- **Unexpected return.** A word returned for a master with `pendN` = 0 is passed through and its counter is left unchanged. Verification flags this as an error.
- **Simultaneous read and write from one master** is illegal input. If it occurs, the read wins.

## Timing

- **Reset values** (applied at the first posedge with `rst` high):
  - `last` = 1, so m0 wins the first tie.
  - `pend0` = `pend1` = 0; `cnt0` = `cnt1` = 0.
  - All `mN_readdatavalid` = 0 whenever `mem_readdataid` is 0.
- **Reset mid-burst.** Pending state is discarded. Words that arrive after reset still strobe `readdatavalid` if their ids match, but they do not re-set `pendN`.
- **No added latency.** The request path and return path are purely combinational. The only registers are `last`, `pend0`/`pend1` and `cnt0`/`cnt1`.
- **Counter width.** `$clog2(BURST)`; the counter never wraps below 0.

## Structure

- Shared package `mem_pkg` holds:
  - the id constants (ID_NONE = 0, ID_IFETCH = 1, ID_DATA = 2);
  - the BURST default.
- One natural sub-module: `burst_tracker`, instantiated twice. Inputs: accept-read strobe and return strobe. Outputs: `pend`. Internally holds `cnt`.
- The grant, mux and waitrequest logic stay in the top level.

## Test plan

- **Reset, single read.** After reset, m0 reads address 0x100 with `mem_waitrequest` = 0.
  - Expect `mem_id` = 1, `mem_read` = 1 and `m0_waitrequest` = 0 in the same cycle.
  - Four ids of 1 then return → `m0_readdatavalid` pulses 4×, and `pend0` clears after the 4th.
- **Contention.** m0 and m1 both write continuously with `mem_waitrequest` = 0 → grants alternate m0, m1, m0, m1; the non-granted master sees `waitrequest` = 1.
- **Ordering block.** m1 reads 0x200, then immediately writes 0x204.
  - The write is held (`m1_waitrequest` = 1) until the cycle after the 4th return with id 2.
  - Meanwhile m0 writes are accepted.
- **Back-pressure.** `mem_waitrequest` = 1 for 10 cycles while m0 requests → `m0_waitrequest` stays 1, with no accept and no change to `last`. Release → accepted in the first cycle with `mem_waitrequest` = 0.
- **Interleaved return and accept.** m0's burst returns while m1's write is accepted in the same cycle → both take effect, and `m1_readdatavalid` stays 0.
- **Reset mid-burst.** Assert `rst` after 2 of 4 words → `pend0` = 0 next cycle, and m0 can issue a new read immediately.
